// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard for stall generation.
module reg_file_sb #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int HAS_ZERO_REG = 1,
    parameter int ZERO_REG     = 31
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] READ_REG_A,
    input  logic [ADDR_W-1:0] READ_REG_B,
    output logic [DATA_W-1:0] DATA_OUT_A,
    output logic [DATA_W-1:0] DATA_OUT_B,
    input  logic              REG_WRITE_ENABLE,
    input  logic [ADDR_W-1:0] WRITE_REG,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic              ISSUE_EN,
    input  logic [ADDR_W-1:0] ISSUE_REG,
    output logic              HAZARD_A,
    output logic              HAZARD_B,
    output logic              STALL,
    output logic [ADDR_W:0]   BUSY_CNT
);

    localparam int          NUM_REGS = 2 ** ADDR_W;
    localparam bit          ZERO_ON  = (HAS_ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic wr_ok, iss_ok, clr_ok, inc;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        wr_ok  = REG_WRITE_ENABLE && !(ZERO_ON && (WRITE_REG == ZERO_IDX));
        iss_ok = ISSUE_EN && !(ZERO_ON && (ISSUE_REG == ZERO_IDX));
        // A same-register issue keeps the bit set, so the writeback clear is suppressed.
        clr_ok = REG_WRITE_ENABLE && busy_q[WRITE_REG] &&
                 !(iss_ok && (ISSUE_REG == WRITE_REG));
        inc    = iss_ok && !busy_q[ISSUE_REG];

        if (wr_ok) begin
            regs_d[WRITE_REG] = WRITE_DATA;
        end
        if (clr_ok) begin
            busy_d[WRITE_REG] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[ISSUE_REG] = 1'b1;
        end
        cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(clr_ok);

        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
        cnt_q  <= cnt_d;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (ZERO_ON && (addr == ZERO_IDX)) begin
            return '0;
        end else if (REG_WRITE_ENABLE && (WRITE_REG == addr)) begin
            return WRITE_DATA;
        end else begin
            return regs_q[addr];
        end
    endfunction

    function automatic logic hazard(input logic [ADDR_W-1:0] addr);
        return busy_q[addr] && !(REG_WRITE_ENABLE && (WRITE_REG == addr)) &&
               !(ZERO_ON && (addr == ZERO_IDX));
    endfunction

    always_comb begin
        DATA_OUT_A = read_port(READ_REG_A);
        DATA_OUT_B = read_port(READ_REG_B);
        HAZARD_A   = hazard(READ_REG_A);
        HAZARD_B   = hazard(READ_REG_B);
        STALL      = HAZARD_A | HAZARD_B;
        BUSY_CNT   = cnt_q;
    end

endmodule
